mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage. Owns the
//  EX/MEM register, the word-addressed data RAM and the MEM/WB register. Consumes the execute
//  outputs (ALU result, store data, destination register, control bits). Produces aluout_mem for
//  forwarding into EXE, the MEM/WB fields, and result_wb, which is fed back to EXE as the second
//  forwarding source.
// PARAMETERS
//  WIDTH       `WIDTH (32)  datapath width, taken from defines.v
//  DEPTH_LOG2  10           log2 of data RAM depth in words (1024 words)
//  INIT_FILE   ""           optional $readmemh image for the RAM; empty = no init
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           synchronous reset, active-low
//  stall_mem      in   1           hold EX/MEM and MEM/WB; suppress RAM write
//  flush_mem      in   1           load a bubble into EX/MEM
//  regwrite_exe   in   1           EXE control: register write
//  memtoreg_exe   in   1           EXE control: WB selects load data
//  memwrite_exe   in   1           EXE control: store
//  regaddr_exe    in   5           destination register from EXE
//  aluout_exe     in   WIDTH       ALU result / byte address from EXE
//  writedata_exe  in   WIDTH       forwarded store data from EXE
//  regwrite_mem   out  1           EX/MEM regwrite, for the hazard/forwarding unit
//  regaddr_mem    out  5           EX/MEM destination register
//  aluout_mem     out  WIDTH       EX/MEM ALU result, for forwarding
//  misalign_mem   out  1           EX/MEM access (load or store) has aluout_mem[1:0] != 0
//  regwrite_wb    out  1           MEM/WB regwrite
//  regaddr_wb     out  5           MEM/WB destination register
//  result_wb      out  WIDTH       memtoreg_wb ? readdata_wb : aluout_wb
// BEHAVIOUR
//  - Reset (rst==0 at a posedge): every EX/MEM and MEM/WB field clears to 0, so all outputs read 0.
//    Reset has priority over flush and stall. RAM contents are not reset.
//  - Priority at each edge: reset > flush_mem > stall_mem > normal load.
//  - EX/MEM register:
//    - normal: captures the *_exe inputs.
//    - flush_mem=1: regwrite, memtoreg and memwrite clear to 0; data fields are don't-care
//      (implementation clears them to 0).
//    - stall_mem=1 and flush_mem=0: holds its contents.
//  - RAM: single port; word index = aluout_mem[DEPTH_LOG2+1:2]; upper address bits are ignored,
//    so addresses wrap modulo 4*2^DEPTH_LOG2.
//    - Write: at the posedge where memwrite_mem=1, stall_mem=0, misalign_mem=0 and rst=1.
//      A store therefore writes exactly once, on the edge it leaves MEM.
//    - Read: synchronous. The word is registered into readdata_wb on the same edge in which
//      MEM/WB loads.
//  - Misaligned access: the store is dropped and misalign_mem=1 while the instruction sits in MEM.
//    A misaligned load returns the word at the truncated index. There is no trap.
//  - MEM/WB register:
//    - normal: captures regwrite, memtoreg, regaddr and aluout from EX/MEM, plus the RAM read word.
//    - stall_mem=1: holds its contents, and the RAM read is not re-latched.
//  - Latency: an instruction at the EXE outputs reaches the EX/MEM outputs 1 edge later and
//    result_wb 2 edges later, absent stalls.
//  - A store followed by a load to the same address, issued back-to-back, returns the new data:
//    the store writes on edge N and the load reads on edge N+1.
//  - Simultaneous flush_mem and stall_mem: flush wins for EX/MEM, while MEM/WB still holds.
//  - result_wb is combinational from the MEM/WB register. Nothing else in the block is
//    combinational from input to output.
// STRUCTURE
//  - Shared package defines.v: `WIDTH and the register-address width (5).
//  - Sub-module data_mem (params WIDTH, DEPTH_LOG2, INIT_FILE):
//    ports clk, we, addr, wdata, re, rdata (registered).
//  - result_wb is built with the existing mux2to1.
//  - The EX/MEM and MEM/WB registers are inline always blocks in mem_stage.
// TESTING
//  1 Reset: hold rst=0 for 2 cycles with random inputs -> all outputs 0 and no RAM write
//    (a read-back of addr 0x10 is unchanged).
//  2 Store/load: store 0xDEADBEEF to 0x40, then load from 0x40 on the next cycle -> after 2 more
//    edges, result_wb=0xDEADBEEF with regwrite_wb=1.
//  3 Forwarding timing: ALU op with aluout_exe=0x1234 and regaddr_exe=5 -> one edge later
//    aluout_mem=0x1234, regaddr_mem=5; one edge after that result_wb=0x1234.
//  4 Misaligned store: store to 0x42 -> misalign_mem=1 for 1 cycle, and word 0x40 is unchanged.
//  5 Stall/flush: hold stall_mem=1 for 3 cycles with a store in MEM -> exactly one RAM write, at
//    release. flush_mem=1 with memwrite_exe=1 -> no write and memwrite_mem=0.
//  6 Reset mid-operation: rst=0 during a store in MEM -> store suppressed, pipeline cleared, and
//    the next instruction proceeds normally once rst returns to 1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared constants for the memory stage of the 5-stage MIPS pipeline:
// datapath width, register-address width and the default data RAM size.
// Also holds the alignment helper used to flag misaligned word accesses.
package mem_stage_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int RAM_DEPTH_LOG2 = 10;

    // A word access is misaligned when it touches memory and the byte
    // offset within the word is non-zero.
    function automatic logic misaligned(input logic access, input logic [1:0] byte_offset);
        return access && (byte_offset != 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// data_mem
// Single-port, word-addressed data RAM with a registered read port.
// Contents are not reset.
// Ports:
//   clk    in   1           rising-edge clock
//   we     in   1           write wdata to addr on this edge
//   addr   in   DEPTH_LOG2  word index
//   wdata  in   WIDTH       write data
//   re     in   1           register the word at addr into rdata on this edge
//   rdata  out  WIDTH       registered read data, held while re = 0
module data_mem #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    // Read returns the pre-write contents when we and re coincide; the
    // pipeline never needs the other ordering because a store and the load
    // behind it occupy MEM on consecutive edges.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_stage_mux2to1.sv
// mux2to1
// Generic two-input multiplexer.
// Ports:
//   sel  in   1      0 selects a, 1 selects b
//   a    in   WIDTH  input chosen when sel = 0
//   b    in   WIDTH  input chosen when sel = 1
//   y    out  WIDTH  selected value (combinational)
module mux2to1 #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory stage of the 5-stage MIPS pipeline. Holds the EX/MEM register,
// the data RAM and the MEM/WB register.
// Ports:
//   clk, rst                       clock; synchronous active-low reset
//   stall_mem                      hold EX/MEM and MEM/WB, suppress RAM write
//   flush_mem                      load a bubble into EX/MEM
//   regwrite_exe, memtoreg_exe,
//   memwrite_exe, regaddr_exe,
//   aluout_exe, writedata_exe      instruction leaving EXE
//   regwrite_mem, regaddr_mem,
//   aluout_mem                     EX/MEM fields for hazard/forwarding logic
//   misalign_mem                   EX/MEM load or store with non-zero byte offset
//   regwrite_wb, regaddr_wb        MEM/WB fields
//   result_wb                      load data or ALU result selected from MEM/WB
// Edge priority: reset > flush (EX/MEM only) > stall > normal load.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WIDTH      = DATA_WIDTH,
    parameter int DEPTH_LOG2 = RAM_DEPTH_LOG2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_mem,
    input  logic                      flush_mem,
    input  logic                      regwrite_exe,
    input  logic                      memtoreg_exe,
    input  logic                      memwrite_exe,
    input  logic [REG_ADDR_WIDTH-1:0] regaddr_exe,
    input  logic [WIDTH-1:0]          aluout_exe,
    input  logic [WIDTH-1:0]          writedata_exe,
    output logic                      regwrite_mem,
    output logic [REG_ADDR_WIDTH-1:0] regaddr_mem,
    output logic [WIDTH-1:0]          aluout_mem,
    output logic                      misalign_mem,
    output logic                      regwrite_wb,
    output logic [REG_ADDR_WIDTH-1:0] regaddr_wb,
    output logic [WIDTH-1:0]          result_wb
);

    logic             memtoreg_mem;
    logic             memwrite_mem;
    logic [WIDTH-1:0] writedata_mem;

    logic             memtoreg_wb;
    logic [WIDTH-1:0] aluout_wb;
    logic [WIDTH-1:0] readdata_wb;

    logic             ram_we;
    logic             ram_re;

    // EX/MEM register. A flush clears every field, not just the controls,
    // so a bubble is all-zero on the forwarding outputs.
    always_ff @(posedge clk) begin
        if (!rst || flush_mem) begin
            regwrite_mem  <= 1'b0;
            memtoreg_mem  <= 1'b0;
            memwrite_mem  <= 1'b0;
            regaddr_mem   <= '0;
            aluout_mem    <= '0;
            writedata_mem <= '0;
        end else if (!stall_mem) begin
            regwrite_mem  <= regwrite_exe;
            memtoreg_mem  <= memtoreg_exe;
            memwrite_mem  <= memwrite_exe;
            regaddr_mem   <= regaddr_exe;
            aluout_mem    <= aluout_exe;
            writedata_mem <= writedata_exe;
        end
    end

    assign misalign_mem = misaligned(memwrite_mem || memtoreg_mem, aluout_mem[1:0]);

    // The store commits on the edge it leaves MEM, so a stall defers it
    // and it still writes exactly once. Misaligned stores are dropped.
    assign ram_we = rst && !stall_mem && memwrite_mem && !misalign_mem;
    // Read data is part of MEM/WB and must not be re-latched while stalled.
    assign ram_re = rst && !stall_mem;

    data_mem #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_data_mem (
        .clk   (clk),
        .we    (ram_we),
        .addr  (aluout_mem[DEPTH_LOG2+1:2]),
        .wdata (writedata_mem),
        .re    (ram_re),
        .rdata (readdata_wb)
    );

    // MEM/WB register. Flush does not reach here: with flush and stall
    // together, this stage still holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regwrite_wb <= 1'b0;
            memtoreg_wb <= 1'b0;
            regaddr_wb  <= '0;
            aluout_wb   <= '0;
        end else if (!stall_mem) begin
            regwrite_wb <= regwrite_mem;
            memtoreg_wb <= memtoreg_mem;
            regaddr_wb  <= regaddr_mem;
            aluout_wb   <= aluout_mem;
        end
    end

    // readdata_wb is not reset, but memtoreg_wb is, so result_wb reads 0.
    mux2to1 #(
        .WIDTH (WIDTH)
    ) u_result_mux (
        .sel (memtoreg_wb),
        .a   (aluout_wb),
        .b   (readdata_wb),
        .y   (result_wb)
    );

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int W  = 32;
    localparam int RW = 5;
    localparam int EW = 1 + RW + W;  // {regwrite, regaddr, result}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          stall_mem, flush_mem;
    logic          regwrite_exe, memtoreg_exe, memwrite_exe;
    logic [RW-1:0] regaddr_exe;
    logic [W-1:0]  aluout_exe, writedata_exe;
    logic          regwrite_mem, misalign_mem, regwrite_wb;
    logic [RW-1:0] regaddr_mem, regaddr_wb;
    logic [W-1:0]  aluout_mem, result_wb;

    mem_stage #(.WIDTH(W), .DEPTH_LOG2(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_mem     (stall_mem),
        .flush_mem     (flush_mem),
        .regwrite_exe  (regwrite_exe),
        .memtoreg_exe  (memtoreg_exe),
        .memwrite_exe  (memwrite_exe),
        .regaddr_exe   (regaddr_exe),
        .aluout_exe    (aluout_exe),
        .writedata_exe (writedata_exe),
        .regwrite_mem  (regwrite_mem),
        .regaddr_mem   (regaddr_mem),
        .aluout_mem    (aluout_mem),
        .misalign_mem  (misalign_mem),
        .regwrite_wb   (regwrite_wb),
        .regaddr_wb    (regaddr_wb),
        .result_wb     (result_wb)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected write-back and compare it with MEM/WB.
    task automatic sb_check(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            failed++;
            $error("FAIL %s: observed empty queue expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'({regwrite_wb, regaddr_wb, result_wb}), 64'(e));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic mtr, input logic mw,
                         input logic [RW-1:0] ra, input logic [W-1:0] alu,
                         input logic [W-1:0] wd);
        regwrite_exe  = rw;
        memtoreg_exe  = mtr;
        memwrite_exe  = mw;
        regaddr_exe   = ra;
        aluout_exe    = alu;
        writedata_exe = wd;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic store(input logic [W-1:0] addr, input logic [W-1:0] data);
        drive(1'b0, 1'b0, 1'b1, '0, addr, data);
    endtask

    // Issue a load and record the value it must return.
    task automatic load(input logic [RW-1:0] ra, input logic [W-1:0] addr, input logic [W-1:0] exp);
        drive(1'b1, 1'b1, 1'b0, ra, addr, W'($urandom));
        exp_q.push_back({1'b1, ra, exp});
    endtask

    task automatic alu_op(input logic [RW-1:0] ra, input logic [W-1:0] val);
        drive(1'b1, 1'b0, 1'b0, ra, val, W'($urandom));
        exp_q.push_back({1'b1, ra, val});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_regwrite_mem"}, 64'(regwrite_mem), 64'(0));
        check({tag, "_regaddr_mem"},  64'(regaddr_mem),  64'(0));
        check({tag, "_aluout_mem"},   64'(aluout_mem),   64'(0));
        check({tag, "_misalign_mem"}, 64'(misalign_mem), 64'(0));
        check({tag, "_regwrite_wb"},  64'(regwrite_wb),  64'(0));
        check({tag, "_regaddr_wb"},   64'(regaddr_wb),   64'(0));
        check({tag, "_result_wb"},    64'(result_wb),    64'(0));
    endtask

    // ---------------- directed steps ----------------
    initial begin
        logic [W-1:0] held;

        stall_mem = 1'b0;
        flush_mem = 1'b0;
        bubble();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        check_all_zero("init_reset");

        // Seed word 0x10 with a known value.
        store(32'h10, 32'hA5A5_0010);
        tick();
        bubble();
        tick();

        // 1: reset with random inputs; no write, outputs all zero.
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            stall_mem = 1'($urandom_range(0, 1));
            flush_mem = 1'($urandom_range(0, 1));
            drive(1'($urandom), 1'($urandom), 1'b1, RW'($urandom), 32'h10, W'($urandom));
            tick();
        end
        check_all_zero("rand_reset");
        rst = 1'b1;
        stall_mem = 1'b0;
        flush_mem = 1'b0;
        load(5'd3, 32'h10, 32'hA5A5_0010);
        tick();
        check("ld10_regwrite_mem", 64'(regwrite_mem), 64'(1));
        check("ld10_regaddr_mem",  64'(regaddr_mem),  64'(3));
        check("ld10_aluout_mem",   64'(aluout_mem),   64'h10);
        bubble();
        tick();
        sb_check("ld10_wb");

        // 2: store then back-to-back load of the same word.
        store(32'h40, 32'hDEAD_BEEF);
        tick();
        load(5'd7, 32'h40, 32'hDEAD_BEEF);
        tick();
        bubble();
        tick();
        sb_check("st_ld_40");

        // 3: forwarding timing of an ALU result.
        alu_op(5'd5, 32'h1234);
        tick();
        check("fwd_aluout_mem",  64'(aluout_mem),  64'h1234);
        check("fwd_regaddr_mem", 64'(regaddr_mem), 64'(5));
        bubble();
        tick();
        sb_check("fwd_wb");

        // 4: misaligned store dropped; misaligned load reads truncated word.
        store(32'h42, 32'h1111_1111);
        tick();
        check("mis_st_flag", 64'(misalign_mem), 64'(1));
        bubble();
        tick();
        check("mis_st_flag_clear", 64'(misalign_mem), 64'(0));
        load(5'd8, 32'h43, 32'hDEAD_BEEF);
        tick();
        check("mis_ld_flag", 64'(misalign_mem), 64'(1));
        bubble();
        tick();
        sb_check("mis_ld_wb");

        // Address wrap: 0x1040 aliases word 0x40.
        load(5'd2, 32'h0000_1040, 32'hDEAD_BEEF);
        tick();
        bubble();
        tick();
        sb_check("wrap_ld");

        // 5a: stall with a store in MEM and a load in MEM/WB.
        load(5'd9, 32'h40, 32'hDEAD_BEEF);
        tick();
        store(32'h80, 32'hCAFE_F00D);
        tick();
        sb_check("pre_stall_wb");
        held = result_wb;
        stall_mem = 1'b1;
        load(5'd10, 32'h80, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_aluout_mem", 64'(aluout_mem), 64'h80);
            check("stall_hold_result_wb",  64'(result_wb),  64'(held));
        end
        stall_mem = 1'b0;
        tick();
        check("release_aluout_mem", 64'(aluout_mem), 64'h80);
        check("release_regaddr_mem", 64'(regaddr_mem), 64'(10));
        bubble();
        tick();
        sb_check("release_ld80");

        // 5b: flushed store never reaches memory.
        flush_mem = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 5'd12, 32'h40, 32'hBAD0_BAD0);
        tick();
        flush_mem = 1'b0;
        check("flush_regwrite_mem", 64'(regwrite_mem), 64'(0));
        check("flush_aluout_mem",   64'(aluout_mem),   64'(0));
        bubble();
        tick();
        load(5'd11, 32'h40, 32'hDEAD_BEEF);
        tick();
        bubble();
        tick();
        sb_check("flush_ld40");

        // 5c: flush and stall together.
        drive(1'b1, 1'b0, 1'b0, 5'd13, 32'h77, '0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd14, 32'h88, '0);
        tick();
        flush_mem = 1'b1;
        stall_mem = 1'b1;
        bubble();
        tick();
        flush_mem = 1'b0;
        stall_mem = 1'b0;
        check("fs_regwrite_mem", 64'(regwrite_mem), 64'(0));
        check("fs_aluout_mem",   64'(aluout_mem),   64'(0));
        check("fs_wb_hold", 64'({regwrite_wb, regaddr_wb, result_wb}), 64'({1'b1, 5'd13, 32'h77}));
        tick();
        check("fs_wb_bubble", 64'({regwrite_wb, regaddr_wb, result_wb}), 64'(0));

        // 6: reset while a store sits in MEM.
        store(32'h40, 32'h1234_5678);
        tick();
        rst = 1'b0;
        bubble();
        tick();
        rst = 1'b1;
        check_all_zero("mid_reset");
        load(5'd15, 32'h40, 32'hDEAD_BEEF);
        tick();
        check("post_rst_regaddr_mem", 64'(regaddr_mem), 64'(15));
        bubble();
        tick();
        sb_check("post_rst_ld40");

        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
